// File: rtl/bp_ltb_stats_table_pkg.sv
// Shared types and helpers for the LTB statistics table.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bp_ltb_stats_table_pkg;

    // Dump sequencer states.
    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_drain = 2'd1,
        e_dump  = 2'd2,
        e_done  = 2'd3
    } bp_ltb_stats_state_e;

    // Wraps v into [0, n) for v in [0, 2n), used to walk channels modulo n.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/bp_ltb_stats_table_arb.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
// Latency: grant is combinational; pointer moves to granted+1 on the next edge.
// Backpressure: en_i low suppresses all grants and freezes the pointer.
module bp_ltb_stats_table_arb
    import bp_ltb_stats_table_pkg::*;
#(
    parameter int num_ch_p = 2
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                en_i,
    input  logic [num_ch_p-1:0] reqs_i,
    output logic [num_ch_p-1:0] grants_o
);

    localparam int ptr_w_lp = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;

    logic [ptr_w_lp-1:0] ptr_q, ptr_d;
    logic [ptr_w_lp-1:0] cand;
    logic                found;

    // Scan channels starting at the pointer; first requester wins.
    always_comb begin
        grants_o = '0;
        ptr_d    = ptr_q;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < num_ch_p; k++) begin
            cand = ptr_w_lp'(rr_wrap(int'(ptr_q) + k, num_ch_p));
            if (en_i && !found && reqs_i[cand]) begin
                grants_o[cand] = 1'b1;
                found          = 1'b1;
                ptr_d          = ptr_w_lp'(rr_wrap(int'(cand) + 1, num_ch_p));
            end
        end
    end

    // Priority pointer advances only when a grant was issued.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bp_ltb_stats_table.sv
// Per-branch LTB statistics: arbitrated events update a tagged direct-mapped table, dumped on demand.
// Latency: update visible 2 cycles after ev_yumi_o; dump 1 beat/cycle, empty entries 1 cycle each.
// Backpressure: events stalled (yumi=0) while dumping; dump beats held until dump_ready_i.
module bp_ltb_stats_table
    import bp_ltb_stats_table_pkg::*;
#(
    parameter int num_ch_p        = 2,
    parameter int els_p           = 64,
    parameter int tag_width_p     = 10,
    parameter int stat_width_p    = 16,
    parameter int vaddr_width_p   = 39,
    parameter int ltb_cnt_width_p = 8,
    localparam int idx_width_lp   = $clog2(els_p),
    localparam int dump_width_lp  = idx_width_lp + tag_width_p + 3*stat_width_p + ltb_cnt_width_p
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_ch_p-1:0]                   ev_v_i,
    output logic [num_ch_p-1:0]                   ev_yumi_o,
    input  logic [num_ch_p-1:0]                   ev_resolve_i,
    input  logic [num_ch_p*vaddr_width_p-1:0]     ev_addr_i,
    input  logic [num_ch_p-1:0]                   ev_mispredict_i,
    input  logic [num_ch_p*ltb_cnt_width_p-1:0]   ev_trip_cnt_i,
    input  logic                                  dump_v_i,
    input  logic                                  clear_on_dump_i,
    output logic                                  dump_v_o,
    input  logic                                  dump_ready_i,
    output logic [dump_width_lp-1:0]              dump_data_o,
    output logic                                  dump_done_o,
    output logic [stat_width_p-1:0]               evict_cnt_o
);

    typedef struct packed {
        logic [tag_width_p-1:0]     tag;
        logic [stat_width_p-1:0]    lookups;
        logic [stat_width_p-1:0]    resolves;
        logic [stat_width_p-1:0]    mispredicts;
        logic [ltb_cnt_width_p-1:0] max_trip;
    } entry_t;

    function automatic logic [stat_width_p-1:0] sat_inc(input logic [stat_width_p-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    bp_ltb_stats_state_e state_q, state_d;
    logic [idx_width_lp-1:0] dump_ptr_q, dump_ptr_d;
    logic                    clear_q, clear_d;
    logic                    dump_clr;

    logic [num_ch_p-1:0]     arb_grants;

    // Stage 1: the accepted event, registered.
    logic                       s1_v_q, s1_v_d;
    logic                       s1_res_q, s1_res_d;
    logic                       s1_mis_q, s1_mis_d;
    logic [ltb_cnt_width_p-1:0] s1_trip_q, s1_trip_d;
    logic [vaddr_width_p-1:0]   s1_addr_d;
    logic [idx_width_lp-1:0]    s1_idx_q;
    logic [tag_width_p-1:0]     s1_tag_q;
    logic                       unused_addr_bits;

    logic [els_p-1:0]           valid_q;
    entry_t                     tbl_q [els_p];
    entry_t                     rd_entry, wr_entry;
    logic                       hit, evict;
    logic [stat_width_p-1:0]    evict_cnt_q;

    bp_ltb_stats_table_arb #(.num_ch_p(num_ch_p)) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (state_q == e_idle),
        .reqs_i    (ev_v_i),
        .grants_o  (arb_grants)
    );

    // Reset forces yumi low even though the state register is already IDLE.
    assign ev_yumi_o = arb_grants & {num_ch_p{reset_n_i}};

    // Mux the granted channel's payload into stage 1.
    always_comb begin
        s1_v_d    = |ev_yumi_o;
        s1_res_d  = 1'b0;
        s1_mis_d  = 1'b0;
        s1_trip_d = '0;
        s1_addr_d = '0;
        for (int ch = 0; ch < num_ch_p; ch++) begin
            if (arb_grants[ch]) begin
                s1_res_d  = ev_resolve_i[ch];
                s1_mis_d  = ev_mispredict_i[ch];
                s1_trip_d = ev_trip_cnt_i[ch*ltb_cnt_width_p +: ltb_cnt_width_p];
                s1_addr_d = ev_addr_i[ch*vaddr_width_p +: vaddr_width_p];
            end
        end
    end

    // Byte offset and PC bits above the tag do not participate in lookup.
    assign unused_addr_bits = ^{s1_addr_d[1:0],
                                s1_addr_d[vaddr_width_p-1:idx_width_lp+2+tag_width_p]};

    // Stage 1 register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q    <= 1'b0;
            s1_res_q  <= 1'b0;
            s1_mis_q  <= 1'b0;
            s1_trip_q <= '0;
            s1_idx_q  <= '0;
            s1_tag_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            if (s1_v_d) begin
                s1_res_q  <= s1_res_d;
                s1_mis_q  <= s1_mis_d;
                s1_trip_q <= s1_trip_d;
                s1_idx_q  <= s1_addr_d[idx_width_lp+1:2];
                s1_tag_q  <= s1_addr_d[idx_width_lp+2 +: tag_width_p];
            end
        end
    end

    // Read-modify-write: reallocate on miss, then apply the event with saturation.
    always_comb begin
        rd_entry = tbl_q[s1_idx_q];
        hit      = valid_q[s1_idx_q] && (rd_entry.tag == s1_tag_q);
        evict    = s1_v_q && valid_q[s1_idx_q] && !hit;
        wr_entry = hit ? rd_entry : '0;
        wr_entry.tag = s1_tag_q;
        if (s1_res_q) begin
            wr_entry.resolves = sat_inc(wr_entry.resolves);
            if (s1_mis_q) begin
                wr_entry.mispredicts = sat_inc(wr_entry.mispredicts);
            end
            if (s1_trip_q > wr_entry.max_trip) begin
                wr_entry.max_trip = s1_trip_q;
            end
        end else begin
            wr_entry.lookups = sat_inc(wr_entry.lookups);
        end
    end

    // Entry payload array: written only by the RMW stage, qualified by valid_q.
    always_ff @(posedge clk_i) begin
        if (s1_v_q) begin
            tbl_q[s1_idx_q] <= wr_entry;
        end
    end

    // Valid bits: set by RMW, cleared by a clear-mode dump handshake (never in the same cycle).
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
        end else begin
            if (s1_v_q) begin
                valid_q[s1_idx_q] <= 1'b1;
            end
            if (dump_clr) begin
                valid_q[dump_ptr_q] <= 1'b0;
            end
        end
    end

    // Saturating eviction counter.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            evict_cnt_q <= '0;
        end else if (evict && !(&evict_cnt_q)) begin
            evict_cnt_q <= evict_cnt_q + 1'b1;
        end
    end

    assign evict_cnt_o = evict_cnt_q;
    assign dump_data_o = {dump_ptr_q, tbl_q[dump_ptr_q]};

    // Dump sequencer next-state and outputs.
    always_comb begin
        state_d     = state_q;
        dump_ptr_d  = dump_ptr_q;
        clear_d     = clear_q;
        dump_v_o    = 1'b0;
        dump_done_o = 1'b0;
        dump_clr    = 1'b0;
        case (state_q)
            e_idle: begin
                if (dump_v_i) begin
                    state_d    = e_drain;
                    clear_d    = clear_on_dump_i;
                    dump_ptr_d = '0;
                end
            end
            e_drain: begin
                state_d = e_dump;
            end
            e_dump: begin
                dump_v_o = valid_q[dump_ptr_q];
                dump_clr = valid_q[dump_ptr_q] && dump_ready_i && clear_q;
                if (!valid_q[dump_ptr_q] || dump_ready_i) begin
                    if (dump_ptr_q == idx_width_lp'(els_p - 1)) begin
                        state_d = e_done;
                    end else begin
                        dump_ptr_d = dump_ptr_q + 1'b1;
                    end
                end
            end
            e_done: begin
                dump_done_o = 1'b1;
                state_d     = e_idle;
            end
            default: begin
                state_d = e_idle;
            end
        endcase
    end

    // Dump sequencer registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_idle;
            dump_ptr_q <= '0;
            clear_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dump_ptr_q <= dump_ptr_d;
            clear_q    <= clear_d;
        end
    end

endmodule
